dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Control stage directly upstream of the 2-way, 16-set data-cache SRAM. Sits between the CPU MEM stage and the line-wide data memory.
- Splits CPU addresses, drives SRAM lookup/write, and stalls the pipeline on a miss.
- Runs the miss sequence: dirty-victim writeback, then line refill, then install.
- Write-back, write-allocate policy; line = 256 bits (8 words).

Parameters:
TAG_W, 23, tag bits (addr[31:9])
IDX_W, 4, set-index bits (addr[8:5])
LINE_W, 256, cache line width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
cpu_addr_i  in  32  byte address
cpu_data_i  in  32  store data
cpu_MemRead_i  in  1  load request
cpu_MemWrite_i  in  1  store request
cpu_data_o  out  32  load data
cpu_stall_o  out  1  pipeline stall
mem_data_i  in  256  refill line
mem_ack_i  in  1  memory transaction done (1-cycle pulse)
mem_addr_o  out  32  line address, [4:0]=0
mem_data_o  out  256  writeback line
mem_enable_o  out  1  memory request
mem_write_o  out  1  1=writeback, 0=refill
sram_addr_o  out  4  set index
sram_tag_o  out  25  {valid, dirty, tag[22:0]}
sram_data_o  out  256  line to write
sram_enable_o  out  1  SRAM access
sram_write_o  out  1  SRAM write
sram_tag_i  in  25  hit way's tag on hit, LRU victim's tag on miss
sram_data_i  in  256  hit line on hit, LRU victim line on miss
sram_hit_i  in  1  lookup hit, combinational from addr/tag same cycle
hit_cnt_o  out  32  hit counter (optional feature)
miss_cnt_o  out  32  miss counter (optional feature)

Behaviour:
- Address split: tag = addr[31:9], index = addr[8:5], word select = addr[4:2]; addr[1:0] ignored.
- req = MemRead | MemWrite. If both are asserted, the access is treated as a store.
- Reset (rst_i low, asynchronous):
  - state = IDLE; refill buffer cleared.
  - All outputs 0 except cpu_data_o = 0 and cpu_stall_o = 0.
  - Reset mid-transaction abandons it: mem_enable_o drops immediately, no SRAM write occurs.
- FSM states: IDLE, MISS, WRITEBACK, REFILL, INSTALL.
- IDLE:
  - sram_enable_o = req; sram_addr_o = index; sram_tag_o = {1, 0, tag}.
  - Load hit: cpu_data_o = word[addr[4:2]] of sram_data_i; stall = 0; zero-cycle latency.
  - Store hit: sram_write_o = 1; sram_data_o = sram_data_i with the selected word replaced by cpu_data_i; sram_tag_o = {1, 1, tag}; committed at the next edge; stall = 0.
  - Miss (req & !hit): cpu_stall_o = 1 combinationally in the same cycle. Latch victim tag, victim line, cpu address, store flag and store data. Next state = MISS.
- MISS (1 cycle):
  - If victim valid & dirty → WRITEBACK, else → REFILL.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1, held until mem_ack_i.
  - mem_addr_o = {victim_tag, index, 5'b0}; mem_data_o = latched victim line.
  - On mem_ack_i → REFILL.
- REFILL:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {tag, index, 5'b0}, held until mem_ack_i.
  - On mem_ack_i, capture mem_data_i into the refill buffer → INSTALL.
- INSTALL (1 cycle):
  - sram_enable_o = 1, sram_write_o = 1.
  - sram_data_o = refill buffer, with the store word merged if the request was a store.
  - sram_tag_o = {1, store_flag, tag}.
  - → IDLE.
- cpu_stall_o = 1 in every non-IDLE state. On return to IDLE the held request re-looks-up and hits, so stall falls that cycle.
- mem_enable_o never toggles while waiting; mem_ack_i outside WRITEBACK/REFILL is ignored.
- CPU inputs are assumed stable while stall is high; the controller uses its latched copies regardless.

Optional Feature:
- Macro DCACHE_PERF_CNT_EN.
- Defined:
  - hit_cnt_o increments on each IDLE-state req & hit cycle where stall = 0.
  - miss_cnt_o increments on each IDLE→MISS transition.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: both ports tied to 0, no counter flops.

Test Plan:
- Cold load 0x0000_0124, victim invalid → stall high; REFILL addr 0x0000_0120; ack after 10 cycles with line word1 = 0xDEADBEEF → INSTALL tag {1,0,0}; next cycle cpu_data_o = 0xDEADBEEF, stall low.
- Store 0x12345678 to 0x0000_0128 after the line above is resident → hit; same-cycle SRAM write with word2 = 0x12345678, tag dirty = 1; no mem_enable_o.
- Load 0x0000_2120 and 0x0000_4120 (same set 9, different tag), with the line from 0x0000_0120 in the victim way dirty → WRITEBACK to 0x0000_0120 with the dirty line first, then REFILL of the new address; exact order and address values checked.
- Store miss to a clean victim → no WRITEBACK; INSTALL tag dirty = 1 with the merged word; a later load of the same address returns the stored value.
- rst_i low during REFILL (before ack) → mem_enable_o = 0 and stall = 0 immediately, no SRAM write; a late mem_ack_i is ignored.
- With DCACHE_PERF_CNT_EN: 3 hits + 2 misses → hit_cnt_o = 3, miss_cnt_o = 2 (re-lookup hits after refill counted as hits); without the macro both read 0.

Source files
------------

// File: rtl/dcache_controller_if.sv
// Bundle of the CPU, line-memory and SRAM-side signals around the data-cache controller.
// The master modport is the controller's view; slave is the surrounding pipeline/memory/SRAM.
interface dcache_controller_if;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;

    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;

    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;

    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    modport master (
        input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        output cpu_data_o, cpu_stall_o,
        input  mem_data_i, mem_ack_i,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        input  sram_tag_i, sram_data_i, sram_hit_i,
        output hit_cnt_o, miss_cnt_o
    );

    modport slave (
        output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        input  cpu_data_o, cpu_stall_o,
        output mem_data_i, mem_ack_i,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        output sram_tag_i, sram_data_i, sram_hit_i,
        input  hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/dcache_controller.sv
// Write-back, write-allocate controller for a 2-way, 16-set data cache with 256-bit lines.
// Define DCACHE_PERF_CNT_EN to build saturating hit/miss counters; otherwise they read 0.
module dcache_controller #(
    parameter int TAG_W  = 23,
    parameter int IDX_W  = 4,
    parameter int LINE_W = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    dcache_controller_if.master bus
);
    typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, INSTALL} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [TAG_W+1:0]    r_victimTag;
    logic [LINE_W-1:0]   r_victimLine;
    logic [LINE_W-1:0]   r_refillBuf;
    logic [31:0]         r_addr;
    logic [31:0]         r_storeData;
    logic                r_isStore;

    logic                w_req;
    logic                w_isStore;
    logic                w_missEvent;
    logic [TAG_W-1:0]    w_tag;
    logic [IDX_W-1:0]    w_index;
    logic [2:0]          w_wordSel;
    logic [TAG_W-1:0]    w_heldTag;
    logic [IDX_W-1:0]    w_heldIndex;
    logic [LINE_W-1:0]   w_installLine;
    logic [1:0]          w_unused;

    assign w_req       = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
    assign w_isStore   = bus.cpu_MemWrite_i;
    assign w_tag       = bus.cpu_addr_i[31:32-TAG_W];
    assign w_index     = bus.cpu_addr_i[31-TAG_W:5];
    assign w_wordSel   = bus.cpu_addr_i[4:2];
    assign w_heldTag   = r_addr[31:32-TAG_W];
    assign w_heldIndex = r_addr[31-TAG_W:5];
    assign w_unused    = bus.cpu_addr_i[1:0];
    assign w_missEvent = (r_state == IDLE) && w_req && !bus.sram_hit_i;

    function automatic logic [LINE_W-1:0] mergeWord(input logic [LINE_W-1:0] line,
                                                    input logic [2:0] sel,
                                                    input logic [31:0] data);
        logic [LINE_W-1:0] merged;
        merged = line;
        merged[{sel, 5'b0} +: 32] = data;
        return merged;
    endfunction

    assign w_installLine = r_isStore ? mergeWord(r_refillBuf, r_addr[4:2], r_storeData)
                                     : r_refillBuf;

    // Everything the miss sequence needs is captured at the missing lookup, so later
    // states never depend on the CPU holding its inputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= IDLE;
            r_victimTag  <= '0;
            r_victimLine <= '0;
            r_refillBuf  <= '0;
            r_addr       <= '0;
            r_storeData  <= '0;
            r_isStore    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_missEvent) begin
                r_victimTag  <= bus.sram_tag_i;
                r_victimLine <= bus.sram_data_i;
                r_addr       <= bus.cpu_addr_i;
                r_isStore    <= w_isStore;
                r_storeData  <= bus.cpu_data_i;
            end
            if (r_state == REFILL && bus.mem_ack_i) begin
                r_refillBuf <= bus.mem_data_i;
            end
        end
    end

    // Outputs are gated by reset so an abandoned memory request drops at once.
    always_comb begin
        bus.cpu_data_o    = '0;
        bus.cpu_stall_o   = 1'b0;
        bus.mem_addr_o    = '0;
        bus.mem_data_o    = '0;
        bus.mem_enable_o  = 1'b0;
        bus.mem_write_o   = 1'b0;
        bus.sram_addr_o   = '0;
        bus.sram_tag_o    = '0;
        bus.sram_data_o   = '0;
        bus.sram_enable_o = 1'b0;
        bus.sram_write_o  = 1'b0;
        w_nextState       = r_state;
        if (rst_i) begin
            case (r_state)
                IDLE: begin
                    bus.sram_enable_o = w_req;
                    bus.sram_addr_o   = w_index;
                    bus.sram_tag_o    = {1'b1, 1'b0, w_tag};
                    if (w_req && bus.sram_hit_i) begin
                        if (w_isStore) begin
                            bus.sram_write_o = 1'b1;
                            bus.sram_data_o  = mergeWord(bus.sram_data_i, w_wordSel, bus.cpu_data_i);
                            bus.sram_tag_o   = {1'b1, 1'b1, w_tag};
                        end else begin
                            bus.cpu_data_o = bus.sram_data_i[{w_wordSel, 5'b0} +: 32];
                        end
                    end else if (w_req) begin
                        bus.cpu_stall_o = 1'b1;
                        w_nextState     = MISS;
                    end
                end
                MISS: begin
                    bus.cpu_stall_o = 1'b1;
                    w_nextState = (r_victimTag[TAG_W+1] && r_victimTag[TAG_W]) ? WRITEBACK : REFILL;
                end
                WRITEBACK: begin
                    bus.cpu_stall_o  = 1'b1;
                    bus.mem_enable_o = 1'b1;
                    bus.mem_write_o  = 1'b1;
                    bus.mem_addr_o   = {r_victimTag[TAG_W-1:0], w_heldIndex, 5'b0};
                    bus.mem_data_o   = r_victimLine;
                    if (bus.mem_ack_i) w_nextState = REFILL;
                end
                REFILL: begin
                    bus.cpu_stall_o  = 1'b1;
                    bus.mem_enable_o = 1'b1;
                    bus.mem_addr_o   = {w_heldTag, w_heldIndex, 5'b0};
                    if (bus.mem_ack_i) w_nextState = INSTALL;
                end
                INSTALL: begin
                    bus.cpu_stall_o   = 1'b1;
                    bus.sram_enable_o = 1'b1;
                    bus.sram_write_o  = 1'b1;
                    bus.sram_addr_o   = w_heldIndex;
                    bus.sram_data_o   = w_installLine;
                    bus.sram_tag_o    = {1'b1, r_isStore, w_heldTag};
                    w_nextState       = IDLE;
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic        w_hitEvent;
    logic [31:0] r_hitCnt;
    logic [31:0] r_missCnt;

    assign w_hitEvent = (r_state == IDLE) && w_req && bus.sram_hit_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_hitCnt  <= '0;
            r_missCnt <= '0;
        end else begin
            if (w_hitEvent && r_hitCnt != 32'hFFFF_FFFF) r_hitCnt <= r_hitCnt + 32'd1;
            if (w_missEvent && r_missCnt != 32'hFFFF_FFFF) r_missCnt <= r_missCnt + 32'd1;
        end
    end

    assign bus.hit_cnt_o  = r_hitCnt;
    assign bus.miss_cnt_o = r_missCnt;
`else
    assign bus.hit_cnt_o  = '0;
    assign bus.miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// Randomized bench for dcache_controller: a 2-way LRU SRAM, a latency-randomized line memory,
// and a word-level reference of memory contents plus per-set recency lists as the golden model.
module tb_dcache_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   dcache_controller_if bus();

   dcache_controller dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   // Default memory image; word 0x124 carries a recognisable value for the cold-load case.
   function automatic logic [31:0] defWord(input logic [29:0] wa);
      if (wa == 30'h49) return 32'hDEAD_BEEF;
      return {wa[29:0], 2'b01} ^ 32'hA5C3_0F1E;
   endfunction

   // SRAM model: 2 ways, 16 sets, one LRU pointer per set naming the victim way.
   logic [24:0]  tagArr  [2][16] = '{default: '0};
   logic [255:0] dataArr [2][16];
   logic         lruArr  [16] = '{default: 1'b0};
   logic         hitWay;
   logic         selWay;
   logic         hitFlag;
   int           wrCount = 0;
   logic [24:0]  lastWrTag = '0;

   always_comb begin
      hitFlag = 1'b0;
      hitWay  = 1'b0;
      for (int w = 0; w < 2; w++) begin
         if (tagArr[w][bus.sram_addr_o][24] && tagArr[w][bus.sram_addr_o][22:0] == bus.sram_tag_o[22:0]) begin
            hitFlag = 1'b1;
            hitWay  = w[0];
         end
      end
      selWay          = hitFlag ? hitWay : lruArr[bus.sram_addr_o];
      bus.sram_hit_i  = hitFlag & bus.sram_enable_o;
      bus.sram_tag_i  = tagArr[selWay][bus.sram_addr_o];
      bus.sram_data_i = dataArr[selWay][bus.sram_addr_o];
   end

   always @(posedge clk) begin
      if (bus.sram_enable_o && bus.sram_write_o) begin
         tagArr[selWay][bus.sram_addr_o]  <= bus.sram_tag_o;
         dataArr[selWay][bus.sram_addr_o] <= bus.sram_data_o;
         lruArr[bus.sram_addr_o]          <= ~selWay;
         wrCount                          <= wrCount + 1;
         lastWrTag                        <= bus.sram_tag_o;
      end else if (bus.sram_enable_o && hitFlag) begin
         lruArr[bus.sram_addr_o] <= ~hitWay;
      end
   end

   // Line memory: acknowledges after a random latency and records every transaction it serves.
   typedef struct {
      logic [31:0]  addr;
      logic         wr;
      logic [255:0] data;
   } memTxn_t;

   memTxn_t      memLog [$];
   logic [31:0]  backMem [logic [29:0]];
   int           fixLat = 0;
   bit           holdRefill = 1'b0;
   int           lateAckReqs = 0;

   function automatic logic [31:0] backWord(input logic [29:0] wa);
      return backMem.exists(wa) ? backMem[wa] : defWord(wa);
   endfunction

   initial begin
      int cnt;
      int curLat;
      int lateAckDone;
      memTxn_t t;
      cnt = 0;
      curLat = 1;
      lateAckDone = 0;
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      forever begin
         @(negedge clk);
         if (bus.mem_ack_i) begin
            bus.mem_ack_i = 1'b0;
            cnt = 0;
         end else if (lateAckReqs != lateAckDone) begin
            bus.mem_ack_i = 1'b1;
            lateAckDone++;
         end else if (!rst_n) begin
            cnt = 0;
         end else if (bus.mem_enable_o && !(holdRefill && !bus.mem_write_o)) begin
            if (cnt == 0) curLat = (fixLat != 0) ? fixLat : int'($urandom_range(1, 8));
            cnt++;
            if (cnt >= curLat) begin
               t.addr = bus.mem_addr_o;
               t.wr   = bus.mem_write_o;
               t.data = bus.mem_data_o;
               if (bus.mem_write_o) begin
                  for (int w = 0; w < 8; w++) backMem[{bus.mem_addr_o[31:5], w[2:0]}] = bus.mem_data_o[w*32 +: 32];
               end else begin
                  for (int w = 0; w < 8; w++) bus.mem_data_i[w*32 +: 32] = backWord({bus.mem_addr_o[31:5], w[2:0]});
                  t.data = bus.mem_data_i;
               end
               memLog.push_back(t);
               bus.mem_ack_i = 1'b1;
            end
         end
      end
   end

   // Reference model: architectural word values plus the two most recently used tags per set.
   logic [31:0]  refMem   [logic [29:0]];
   bit           dirtyMap [logic [26:0]];
   logic [22:0]  recent   [16][2];
   int           fill     [16] = '{default: 0};
   int           expHits = 0;
   int           expMisses = 0;
   int           logRd = 0;

   function automatic logic [31:0] refWord(input logic [29:0] wa);
      return refMem.exists(wa) ? refMem[wa] : defWord(wa);
   endfunction

   function automatic logic [255:0] refLine(input logic [26:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = refWord({la, w[2:0]});
      return l;
   endfunction

   task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic checkCounters();
`ifdef DCACHE_PERF_CNT_EN
      checkOutput("hitCnt", bus.hit_cnt_o, expHits);
      checkOutput("missCnt", bus.miss_cnt_o, expMisses);
`else
      checkOutput("hitCnt", bus.hit_cnt_o, 0);
      checkOutput("missCnt", bus.miss_cnt_o, 0);
`endif
   endtask

   // One CPU access: predict hit/miss and memory traffic from the model, drive, then check.
   task automatic applyStimulus(input logic [31:0] addr, input bit isStore, input bit both, input logic [31:0] data);
      logic [22:0] tag;
      logic [3:0]  idx;
      logic [29:0] wa;
      logic [22:0] victim;
      bit          expHit, expWb;
      int          sel, cycles, pend;
      tag = addr[31:9];
      idx = addr[8:5];
      wa  = addr[31:2];
      sel = int'(addr[4:2]);
      expHit = (fill[idx] > 0 && recent[idx][0] == tag) || (fill[idx] > 1 && recent[idx][1] == tag);
      expWb  = 1'b0;
      victim = '0;
      if (!expHit && fill[idx] == 2) begin
         victim = recent[idx][1];
         expWb  = dirtyMap.exists({victim, idx});
      end

      @(posedge clk); #1;
      bus.cpu_addr_i     = addr;
      bus.cpu_data_i     = data;
      bus.cpu_MemWrite_i = isStore;
      bus.cpu_MemRead_i  = !isStore || both;
      @(negedge clk);
      checkOutput("stall", bus.cpu_stall_o, !expHit);
      if (expHit) begin
         checkOutput("noMemReq", bus.mem_enable_o, 0);
         if (isStore) begin
            checkOutput("storeHitWrite", bus.sram_write_o, 1);
            checkOutput("storeHitWord", bus.sram_data_o[sel*32 +: 32], data);
            checkOutput("storeHitTag", bus.sram_tag_o, {2'b11, tag});
         end else begin
            checkOutput("loadHitData", bus.cpu_data_o, refWord(wa));
         end
      end else begin
         cycles = 0;
         while (bus.cpu_stall_o && cycles < 200) begin
            @(negedge clk);
            cycles++;
         end
         checkOutput("missDone", bus.cpu_stall_o, 0);
         if (!isStore) checkOutput("missLoadData", bus.cpu_data_o, refWord(wa));
         pend = memLog.size() - logRd;
         checkOutput("memTxnCount", pend, expWb ? 2 : 1);
         if (expWb && pend >= 1) begin
            checkOutput("wbIsWrite", memLog[logRd].wr, 1);
            checkOutput("wbAddr", memLog[logRd].addr, {victim, idx, 5'b0});
            checkOutput("wbData", memLog[logRd].data, refLine({victim, idx}));
            logRd++;
         end
         if (memLog.size() > logRd) begin
            checkOutput("refillIsRead", memLog[logRd].wr, 0);
            checkOutput("refillAddr", memLog[logRd].addr, {tag, idx, 5'b0});
         end
         logRd = memLog.size();
         checkOutput("installTag", lastWrTag, {1'b1, isStore, tag});
      end

      if (expHit && fill[idx] > 1 && recent[idx][1] == tag) begin
         recent[idx][1] = recent[idx][0];
         recent[idx][0] = tag;
      end else if (!expHit) begin
         if (fill[idx] == 2) dirtyMap.delete({victim, idx});
         recent[idx][1] = recent[idx][0];
         recent[idx][0] = tag;
         if (fill[idx] < 2) fill[idx]++;
         expMisses++;
      end
      expHits++;
      if (isStore) begin
         refMem[wa] = data;
         dirtyMap[{tag, idx}] = 1'b1;
      end

      @(posedge clk); #1;
      bus.cpu_MemRead_i  = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
   endtask

   // Abandon a refill with reset, then show a stray acknowledge changes nothing.
   task automatic applyResetDuringRefill();
      int cycles;
      int wrBefore;
      holdRefill = 1'b1;
      @(posedge clk); #1;
      bus.cpu_addr_i    = 32'h0000_01E4;
      bus.cpu_MemRead_i = 1'b1;
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!(bus.mem_enable_o && !bus.mem_write_o) && cycles < 50);
      checkOutput("reachedRefill", bus.mem_enable_o, 1);
      repeat (3) @(negedge clk);
      wrBefore = wrCount;
      rst_n = 1'b0;
      #1;
      checkOutput("rstMemEnable", bus.mem_enable_o, 0);
      checkOutput("rstStall", bus.cpu_stall_o, 0);
      checkOutput("rstSramWrite", bus.sram_write_o, 0);
      lateAckReqs++;
      bus.cpu_MemRead_i = 1'b0;
      expHits = 0;
      expMisses = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      holdRefill = 1'b0;
      lateAckReqs++;
      repeat (4) @(negedge clk);
      checkOutput("postRstMemEnable", bus.mem_enable_o, 0);
      checkOutput("postRstStall", bus.cpu_stall_o, 0);
      checkOutput("noSramWriteAfterRst", wrCount, wrBefore);
      checkOutput("noMemTxnAfterRst", memLog.size(), logRd);
      checkCounters();
   endtask

   initial begin
      logic [22:0] tagPool [5];
      logic [3:0]  idxPool [4];
      logic [31:0] a;
      tagPool = '{23'h0, 23'h10, 23'h20, 23'h30, 23'h7FFFFF};
      idxPool = '{4'd0, 4'd1, 4'd2, 4'd9};
      bus.cpu_addr_i     = '0;
      bus.cpu_data_i     = '0;
      bus.cpu_MemRead_i  = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
      #12;
      checkOutput("resetStall", bus.cpu_stall_o, 0);
      checkOutput("resetMemEnable", bus.mem_enable_o, 0);
      checkOutput("resetCpuData", bus.cpu_data_o, 0);
      checkCounters();
      @(negedge clk);
      rst_n = 1'b1;

      fixLat = 10;
      applyStimulus(32'h0000_0124, 1'b0, 1'b0, 32'h0);
      checkOutput("coldLoadWord", bus.cpu_data_o, 32'hDEAD_BEEF);
      fixLat = 0;
      applyStimulus(32'h0000_0128, 1'b1, 1'b0, 32'h1234_5678);
      applyStimulus(32'h0000_2120, 1'b0, 1'b0, 32'h0);
      applyStimulus(32'h0000_4120, 1'b0, 1'b0, 32'h0);
      applyStimulus(32'h0000_6124, 1'b1, 1'b1, 32'hCAFE_F00D);
      applyStimulus(32'h0000_6124, 1'b0, 1'b0, 32'h0);
      applyStimulus(32'h0000_0128, 1'b0, 1'b0, 32'h0);
      checkCounters();

      applyResetDuringRefill();
      applyStimulus(32'h0000_01E4, 1'b0, 1'b0, 32'h0);

      for (int n = 0; n < 250; n++) begin
         a = {tagPool[$urandom_range(0, 4)], idxPool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         applyStimulus(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end
      checkCounters();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
